fetch_sequencer: RTL and testbench

Control FSM for the fetch stage. It sequences each instruction-memory access with a request/ready handshake and decides when the PC register loads. It drives the 3-way next-PC select (incremented PC, branch target, ALU result) and counts retired fetches. It sits between the fetch datapath and decode/branch-resolution logic, and replaces the free-running PC update.

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_wait_timer.sv | 29 ++
 rtl/fetch_sequencer.sv | 74 +++++++
 tb/tb_fetch_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: next-PC select codes and FSM state encodings.
package fetch_sequencer_pkg;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_ALU    = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    function automatic logic [1:0] redirect_src(input logic valid, input logic kind);
        return valid ? (kind ? PC_SRC_ALU : PC_SRC_BRANCH) : PC_SRC_INC;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Memory-wait up-counter: cleared in REQ, counts WAIT cycles, flags the cycle that reaches the limit.
module fetch_wait_timer #(
    parameter int MEM_LATENCY_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int W = $clog2(MEM_LATENCY_MAX + 1);
    localparam logic [W-1:0] LAST = W'(MEM_LATENCY_MAX - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

    // Asserted on the enabled cycle whose increment brings the count to MEM_LATENCY_MAX.
    assign done = en && (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: imem handshake, PC load/select, flush on redirect, retired-fetch count.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int MEM_LATENCY_MAX = 15,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic                 redirect_kind,
    input  logic                 halt_req,
    input  logic                 imem_ready,
    output logic                 imem_req,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 instr_valid,
    output logic                 flush,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    logic [2:0] state, state_nxt;
    logic       accept;
    logic       timer_done;

    fetch_wait_timer #(.MEM_LATENCY_MAX(MEM_LATENCY_MAX)) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_REQ),
        .en    (state == ST_WAIT),
        .done  (timer_done)
    );

    assign accept      = (state == ST_ISSUE) && !stall;
    assign instr_valid = (state == ST_ISSUE);
    assign pc_we       = accept;
    assign pc_src      = accept ? redirect_src(redirect_valid, redirect_kind) : PC_SRC_INC;
    assign flush       = accept && redirect_valid;

    assign imem_req    = (state == ST_REQ) || (state == ST_WAIT);
    assign busy        = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_ISSUE);
    assign timeout_err = (state == ST_ERROR);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_REQ;
            ST_REQ:    state_nxt = imem_ready ? ST_ISSUE : ST_WAIT;
            // A late ready still wins over the timeout in the same cycle.
            ST_WAIT:   if (imem_ready) state_nxt = ST_ISSUE;
                       else if (timer_done) state_nxt = ST_ERROR;
            ST_ISSUE:  if (accept) state_nxt = halt_req ? ST_HALTED : ST_REQ;
            ST_HALTED: if (start) state_nxt = ST_REQ;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                fetch_count <= fetch_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scripted bench for fetch_sequencer; accepted fetches are scoreboarded against pc_we pulses.
module tb_fetch_sequencer;

    localparam int CW = 4;
    localparam int ML = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, stall = 1'b0, redirect_valid = 1'b0, redirect_kind = 1'b0;
    logic halt_req = 1'b0, imem_ready = 1'b0;
    logic imem_req, pc_we, instr_valid, flush, busy, timeout_err;
    logic [1:0] pc_src;
    logic [CW-1:0] fetch_count;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_count = '0;

    typedef struct packed {
        logic [1:0] src;
        logic       flush;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    fetch_sequencer #(.MEM_LATENCY_MAX(ML), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .halt_req       (halt_req),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .pc_we          (pc_we),
        .pc_src         (pc_src),
        .instr_valid    (instr_valid),
        .flush          (flush),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Every pc_we pulse must match the oldest expected accept.
    always @(negedge clk) begin
        #2;
        if (pc_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pc_we: pc_src=%b flush=%b with no accept expected", pc_src, flush);
            end else begin
                mon_e = sb.pop_front();
                if ({pc_src, flush} !== {mon_e.src, mon_e.flush}) begin
                    errors++;
                    $display("FAIL sb_accept: pc_src=%b flush=%b expected pc_src=%b flush=%b",
                             pc_src, flush, mon_e.src, mon_e.flush);
                end
            end
        end
    end

    task automatic clear_inputs();
        start = 0; stall = 0; redirect_valid = 0; redirect_kind = 0; halt_req = 0; imem_ready = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 0;
        clear_inputs();
        sb.delete();
        exp_count = '0;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic start_req();
        @(negedge clk);
        clear_inputs();
        start = 1;
        #1;
        checks++;
        if ({imem_req, instr_valid, pc_we} !== 3'b000) begin
            errors++;
            $display("FAIL start_idle: req/valid/we=%b expected 000", {imem_req, instr_valid, pc_we});
        end
    endtask

    // First cycle of this task must be the REQ state.
    task automatic do_fetch(input int nwait, input int nstall, input logic rv, input logic rk, input logic hr);
        exp_t e;
        @(negedge clk);
        clear_inputs();
        imem_ready = (nwait == 0);
        #1;
        checks++;
        if ({imem_req, busy, instr_valid, pc_we, timeout_err} !== 5'b11000) begin
            errors++;
            $display("FAIL req_phase: req/busy/valid/we/err=%b expected 11000",
                     {imem_req, busy, instr_valid, pc_we, timeout_err});
        end
        checks++;
        if (fetch_count !== exp_count) begin
            errors++;
            $display("FAIL fetch_count: got %0d expected %0d", fetch_count, exp_count);
        end
        for (int i = 1; i <= nwait; i++) begin
            @(negedge clk);
            imem_ready = (i == nwait);
            #1;
            checks++;
            if ({imem_req, instr_valid, pc_we, timeout_err} !== 4'b1000) begin
                errors++;
                $display("FAIL wait_phase cycle %0d: req/valid/we/err=%b expected 1000",
                         i, {imem_req, instr_valid, pc_we, timeout_err});
            end
        end
        for (int i = 0; i < nstall; i++) begin
            @(negedge clk);
            imem_ready = 0; stall = 1; redirect_valid = rv; redirect_kind = rk; halt_req = hr;
            #1;
            checks++;
            if ({instr_valid, pc_we, pc_src, flush, imem_req} !== 6'b100000) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: valid/we/src/flush/req=%b expected 100000",
                         i, {instr_valid, pc_we, pc_src, flush, imem_req});
            end
        end
        @(negedge clk);
        imem_ready = 0; stall = 0; redirect_valid = rv; redirect_kind = rk; halt_req = hr;
        e.src = rv ? (rk ? 2'b10 : 2'b01) : 2'b00;
        e.flush = rv;
        sb.push_back(e);
        exp_count = exp_count + 1'b1;
        #1;
        checks++;
        if ({instr_valid, pc_we, imem_req} !== 3'b110) begin
            errors++;
            $display("FAIL accept: valid/we/req=%b expected 110", {instr_valid, pc_we, imem_req});
        end
    endtask

    task automatic check_halted();
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({busy, imem_req, instr_valid, pc_we, flush, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL halted_outputs: busy/req/valid/we/flush/err=%b expected 000000",
                     {busy, imem_req, instr_valid, pc_we, flush, timeout_err});
        end
        checks++;
        if (fetch_count !== exp_count) begin
            errors++;
            $display("FAIL halted_count: got %0d expected %0d", fetch_count, exp_count);
        end
    endtask

    task automatic test_reset_state();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({imem_req, pc_we, pc_src, instr_valid, flush, busy, timeout_err, fetch_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%b count=%0d expected all 0",
                     {imem_req, pc_we, pc_src, instr_valid, flush, busy, timeout_err}, fetch_count);
        end
        reset = 1;
    endtask

    task automatic test_back_to_back();
        start_req();
        for (int i = 0; i < 4; i++) do_fetch(0, 0, 1'b0, 1'b0, i == 3);
        check_halted();
        checks++;
        if (fetch_count !== 4'd4) begin
            errors++;
            $display("FAIL back_to_back_count: got %0d expected 4", fetch_count);
        end
    endtask

    task automatic test_stall_redirect();
        start_req();
        do_fetch(1, 3, 1'b1, 1'b0, 1'b0);
        do_fetch(0, 0, 1'b0, 1'b0, 1'b1);
        check_halted();
    endtask

    task automatic test_halt_redirect();
        start_req();
        do_fetch(2, 0, 1'b1, 1'b1, 1'b1);
        check_halted();
        start_req();
        do_fetch(0, 0, 1'b0, 1'b0, 1'b1);
        check_halted();
    endtask

    task automatic test_reset();
        start_req();
        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if ({imem_req, pc_we, pc_src, instr_valid, flush, busy, timeout_err, fetch_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: outputs=%b count=%0d expected all 0",
                     {imem_req, pc_we, pc_src, instr_valid, flush, busy, timeout_err}, fetch_count);
        end
        sb.delete();
        exp_count = '0;
        @(negedge clk);
        reset = 1;
        start_req();
        do_fetch(0, 0, 1'b0, 1'b0, 1'b1);
        check_halted();
    endtask

    task automatic test_timeout();
        start_req();
        @(negedge clk);
        clear_inputs();
        for (int i = 1; i <= ML; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({imem_req, timeout_err} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: req/err=%b expected 10", i, {imem_req, timeout_err});
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1;
            #1;
            checks++;
            if ({timeout_err, busy, imem_req, instr_valid, pc_we} !== 5'b10000) begin
                errors++;
                $display("FAIL timeout_sticky cycle %0d: err/busy/req/valid/we=%b expected 10000",
                         i, {timeout_err, busy, imem_req, instr_valid, pc_we});
            end
        end
        pulse_reset();
        start_req();
        do_fetch(ML, 0, 1'b0, 1'b0, 1'b1);
        check_halted();
    endtask

    task automatic test_wrap();
        pulse_reset();
        start_req();
        for (int i = 0; i < 17; i++) do_fetch(i % 3, 0, 1'b0, 1'b0, i == 16);
        check_halted();
        checks++;
        if (fetch_count !== 4'd1) begin
            errors++;
            $display("FAIL count_wrap: got %0d expected 1", fetch_count);
        end
    endtask

    initial begin
        test_reset_state();
        test_back_to_back();
        test_stall_redirect();
        test_halt_redirect();
        test_reset();
        test_timeout();
        test_wrap();
        @(negedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected accepts never seen", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
